// File: rtl/red_pitaya_trigger_timestamp_fifo_pkg.sv
// Shared definitions for the trigger timestamp FIFO: register map, entry
// layout and small helpers used by the register front end.
package red_pitaya_trigger_timestamp_fifo_pkg;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;

    // Entry layout: {timestamp[63:0], phase[13:0], dat[13:0]} = 92 bits
    localparam int TS_W      = 64;
    localparam int PHASE_W   = 14;
    localparam int DAT_W     = 14;
    localparam int ENTRY_W   = 92;
    localparam int DAT_LSB   = 0;
    localparam int PHASE_LSB = 14;
    localparam int TS_LSB    = 28;

    // Register offsets
    localparam logic [15:0] ADDR_CTRL   = 16'h0100;
    localparam logic [15:0] ADDR_STATUS = 16'h0104;
    localparam logic [15:0] ADDR_TS_LO  = 16'h0108;
    localparam logic [15:0] ADDR_TS_HI  = 16'h010C;
    localparam logic [15:0] ADDR_HEAD   = 16'h0110;
    localparam logic [15:0] ADDR_PARAM  = 16'h0120;

    // Control register bit positions
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    typedef struct packed {
        logic [63:0] ts;
        logic [13:0] phase;
        logic [13:0] dat;
    } entry_t;

    typedef enum logic [2:0] {
        SEL_NONE   = 3'd0,
        SEL_CTRL   = 3'd1,
        SEL_STATUS = 3'd2,
        SEL_TS_LO  = 3'd3,
        SEL_TS_HI  = 3'd4,
        SEL_HEAD   = 3'd5,
        SEL_PARAM  = 3'd6
    } reg_sel_e;

    // Map a bus address onto the register it selects.
    function automatic reg_sel_e decode_addr(input logic [15:0] addr);
        case (addr)
            ADDR_CTRL:   return SEL_CTRL;
            ADDR_STATUS: return SEL_STATUS;
            ADDR_TS_LO:  return SEL_TS_LO;
            ADDR_TS_HI:  return SEL_TS_HI;
            ADDR_HEAD:   return SEL_HEAD;
            ADDR_PARAM:  return SEL_PARAM;
            default:     return SEL_NONE;
        endcase
    endfunction

    // Saturating increment for the overflow counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // The status field is 8 bits wide; a full 256-deep FIFO reports 0xFF.
    function automatic logic [7:0] fill_byte(input logic [8:0] c);
        return c[8] ? 8'hFF : c[7:0];
    endfunction

    // Head data word as seen on the bus.
    function automatic logic [31:0] head_word(input logic [13:0] dat, input logic [13:0] phase);
        return {2'b00, dat, 2'b00, phase};
    endfunction

endpackage

// File: rtl/red_pitaya_trigger_timestamp_fifo_if.sv
// Register bus between a bus master and the trigger timestamp FIFO.
interface red_pitaya_trigger_timestamp_fifo_if;
    import red_pitaya_trigger_timestamp_fifo_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic              ren;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output addr, output wen, output ren, output wdata,
                    input  ack,  input  rdata);
    modport slave  (input  addr, input  wen, input  ren, input  wdata,
                    output ack,  output rdata);
endinterface

// File: rtl/red_pitaya_trigger_timestamp_fifo_mem.sv
// Simple dual-port entry storage: one write port, one registered read port.
// A read of the address being written in the same cycle returns the new
// data, so a freshly pushed entry can become the head without a bubble.
module trigger_fifo_mem
    import red_pitaya_trigger_timestamp_fifo_pkg::*;
#(
    parameter int AW = 4,
    parameter int W  = ENTRY_W
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_r [0:(32'd1 << AW)-1];
    logic [W-1:0] rdata_r;

    // Storage write; contents are not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read with write-first forwarding on address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= {W{1'b0}};
        end else if (we && (waddr == raddr)) begin
            rdata_r <= wdata;
        end else begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/red_pitaya_trigger_timestamp_fifo.sv
// Trigger timestamp FIFO: every enabled trigger pulse records the free-running
// 64-bit counter together with the phase and signal samples. Software drains
// the entries through a small register map; reading the head data word pops.
// DEPTH_LOG2 is legal from 2 to 8.
module red_pitaya_trigger_timestamp_fifo
    import red_pitaya_trigger_timestamp_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
)
(
    input  logic                                  clk_i,
    input  logic                                  rstn_i,
    input  logic                                  trig_i,
    input  logic [13:0]                           phase_i,
    input  logic [13:0]                           dat_i,
    red_pitaya_trigger_timestamp_fifo_if.slave    bus,
    output logic                                  nonempty_o
);

    localparam int PTR_W = DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(32'd1 << DEPTH_LOG2);

    logic [63:0]        counter_r;
    logic               enable_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [15:0]        overflow_r;
    logic               ack_r;
    logic [31:0]        rdata_r;
    logic               nonempty_r;

    logic [PTR_W-1:0]   wr_ptr_s;
    logic [PTR_W-1:0]   rd_ptr_s;
    logic [CNT_W-1:0]   count_s;
    logic [15:0]        overflow_s;
    logic [31:0]        rdata_s;

    reg_sel_e           sel_s;
    logic               ctrl_wr_s;
    logic               srst_s;
    logic               empty_s;
    logic               full_s;
    logic               push_req_s;
    logic               pop_s;
    logic               push_ok_s;
    logic               mem_we_s;
    entry_t             push_entry_s;
    logic [ENTRY_W-1:0] mem_rdata_s;
    logic [63:0]        head_ts_s;
    logic [13:0]        head_phase_s;
    logic [13:0]        head_dat_s;
    logic               unused_wdata_s;

    assign unused_wdata_s = ^bus.wdata[31:2];

    // Decode the bus access and derive push/pop/clear for this cycle.
    // The ctrl clear bit acts as a synchronous soft reset of the FIFO.
    always_comb begin
        sel_s      = decode_addr(bus.addr);
        ctrl_wr_s  = bus.wen && (sel_s == SEL_CTRL);
        srst_s     = ctrl_wr_s && bus.wdata[CTRL_CLR_BIT];
        empty_s    = (count_r == {CNT_W{1'b0}});
        full_s     = (count_r == DEPTH_CNT);
        push_req_s = trig_i && enable_r;
        pop_s      = bus.ren && (sel_s == SEL_HEAD) && !empty_s;
        // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
        push_ok_s  = push_req_s && (!full_s || pop_s);
        mem_we_s   = push_ok_s && !srst_s;
        push_entry_s.ts    = counter_r;
        push_entry_s.phase = phase_i;
        push_entry_s.dat   = dat_i;
    end

    // Next pointer, fill and overflow state; clear wins over push and pop.
    always_comb begin
        wr_ptr_s   = wr_ptr_r;
        rd_ptr_s   = rd_ptr_r;
        count_s    = count_r;
        overflow_s = overflow_r;
        if (srst_s) begin
            wr_ptr_s   = {PTR_W{1'b0}};
            rd_ptr_s   = {PTR_W{1'b0}};
            count_s    = {CNT_W{1'b0}};
            overflow_s = 16'd0;
        end else begin
            wr_ptr_s = wr_ptr_r + PTR_W'(push_ok_s);
            rd_ptr_s = rd_ptr_r + PTR_W'(pop_s);
            count_s  = count_r + CNT_W'(push_ok_s) - CNT_W'(pop_s);
            if (push_req_s && !push_ok_s) begin
                overflow_s = sat_inc16(overflow_r);
            end else begin
                overflow_s = overflow_r;
            end
        end
    end

    // The memory reads at the next read pointer so the head is ready a
    // cycle after any push or pop.
    trigger_fifo_mem #(
        .AW (PTR_W),
        .W  (ENTRY_W)
    ) u_mem (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .we    (mem_we_s),
        .waddr (wr_ptr_r),
        .wdata (push_entry_s),
        .raddr (rd_ptr_s),
        .rdata (mem_rdata_s)
    );

    // Split the head entry into its fields.
    always_comb begin
        head_ts_s    = mem_rdata_s[TS_LSB +: TS_W];
        head_phase_s = mem_rdata_s[PHASE_LSB +: PHASE_W];
        head_dat_s   = mem_rdata_s[DAT_LSB +: DAT_W];
    end

    // Register read multiplexer; head registers read 0 when empty.
    always_comb begin
        rdata_s = 32'd0;
        case (sel_s)
            SEL_CTRL:   rdata_s = {31'd0, enable_r};
            SEL_STATUS: rdata_s = {overflow_r, fill_byte(9'(count_r)), 6'd0, full_s, empty_s};
            SEL_TS_LO:  rdata_s = empty_s ? 32'd0 : head_ts_s[31:0];
            SEL_TS_HI:  rdata_s = empty_s ? 32'd0 : head_ts_s[63:32];
            SEL_HEAD:   rdata_s = empty_s ? 32'd0 : head_word(head_dat_s, head_phase_s);
            SEL_PARAM:  rdata_s = 32'(DEPTH_LOG2);
            default:    rdata_s = 32'd0;
        endcase
    end

    // Free-running timestamp counter.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            counter_r <= 64'd0;
        end else begin
            counter_r <= counter_r + 64'd1;
        end
    end

    // Enable bit and FIFO bookkeeping state.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            enable_r   <= 1'b0;
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 16'd0;
        end else begin
            if (ctrl_wr_s) begin
                enable_r <= bus.wdata[CTRL_EN_BIT];
            end
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            count_r    <= count_s;
            overflow_r <= overflow_s;
        end
    end

    // Bus acknowledge and read data, one cycle after each access.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ack_r   <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            ack_r <= bus.wen || bus.ren;
            if (bus.wen || bus.ren) begin
                rdata_r <= bus.ren ? rdata_s : 32'd0;
            end
        end
    end

    // Registered non-empty flag, aligned with the status register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            nonempty_r <= 1'b0;
        end else begin
            nonempty_r <= (count_s != {CNT_W{1'b0}});
        end
    end

    assign bus.ack    = ack_r;
    assign bus.rdata  = rdata_r;
    assign nonempty_o = nonempty_r;

endmodule

// File: tb/tb_red_pitaya_trigger_timestamp_fifo.sv
// Self-checking bench for the trigger timestamp FIFO. A behavioural queue
// model predicts every register read; expectations are queued when a bus
// access is driven and compared when the acknowledge comes back.
module tb_red_pitaya_trigger_timestamp_fifo;

    localparam int DEPTH = 16;

    logic        clk_i;
    logic        rstn_i;
    logic        trig_i;
    logic [13:0] phase_i;
    logic [13:0] dat_i;
    logic        nonempty_o;

    red_pitaya_trigger_timestamp_fifo_if bus ();

    red_pitaya_trigger_timestamp_fifo #(.DEPTH_LOG2(4)) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .trig_i     (trig_i),
        .phase_i    (phase_i),
        .dat_i      (dat_i),
        .bus        (bus.slave),
        .nonempty_o (nonempty_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    int ncyc     = 0;

    // Model state
    logic [63:0] model_ts = 64'd0;
    logic [91:0] model_q[$];
    logic [15:0] model_ovf = 16'd0;
    bit          model_en  = 1'b0;

    // Scoreboard of outstanding bus accesses
    logic [31:0] exp_d[$];
    bit          exp_chk[$];
    int          exp_cyc[$];

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Cycle counter and expected timestamp counter.
    always @(posedge clk_i) begin
        ncyc <= ncyc + 1;
        if (!rstn_i) model_ts <= 64'd0;
        else         model_ts <= model_ts + 64'd1;
    end

    function automatic logic [31:0] model_rd(input logic [15:0] a);
        logic [91:0] h;
        bit          e;
        e = (model_q.size() == 0);
        h = e ? 92'd0 : model_q[0];
        case (a)
            16'h0100: return {31'd0, model_en};
            16'h0104: return {model_ovf, 8'(model_q.size()), 6'd0,
                              (model_q.size() == DEPTH), e};
            16'h0108: return h[59:28];
            16'h010C: return h[91:60];
            16'h0110: return {2'b00, h[13:0], 2'b00, h[27:14]};
            16'h0120: return 32'd4;
            default:  return 32'd0;
        endcase
    endfunction

    // One clock cycle of stimulus, with the model advanced alongside.
    task automatic step(input bit trig, input logic [13:0] ph, input logic [13:0] dt,
                        input bit rd, input bit wr, input logic [15:0] a, input logic [31:0] wd);
        bit new_en, clr, push_req, pop;
        trig_i    = trig;
        phase_i   = ph;
        dat_i     = dt;
        bus.ren   = rd;
        bus.wen   = wr;
        bus.addr  = a;
        bus.wdata = wd;
        if (rd || wr) begin
            exp_d.push_back(rd ? model_rd(a) : 32'd0);
            exp_chk.push_back(rd);
            exp_cyc.push_back(ncyc);
        end
        new_en = model_en;
        clr    = 1'b0;
        if (wr && a == 16'h0100) begin
            new_en = wd[0];
            clr    = wd[1];
        end
        push_req = trig && model_en;
        pop      = rd && (a == 16'h0110) && (model_q.size() > 0);
        if (clr) begin
            model_q.delete();
            model_ovf = 16'd0;
        end else begin
            if (pop) model_q.delete(0);
            if (push_req) begin
                if (model_q.size() < DEPTH) model_q.push_back({model_ts, ph, dt});
                else if (model_ovf != 16'hFFFF) model_ovf = model_ovf + 16'd1;
            end
        end
        model_en = new_en;
        @(negedge clk_i);
        check_val("nonempty", {63'd0, nonempty_o}, {63'd0, (model_q.size() != 0)});
    endtask

    task automatic idle();
        step(1'b0, 14'd0, 14'd0, 1'b0, 1'b0, 16'd0, 32'd0);
    endtask

    task automatic pulse();
        step(1'b1, 14'($urandom), 14'($urandom), 1'b0, 1'b0, 16'd0, 32'd0);
    endtask

    task automatic rd(input logic [15:0] a);
        step(1'b0, 14'd0, 14'd0, 1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic rd_cap(input logic [15:0] a, output logic [31:0] v);
        step(1'b0, 14'd0, 14'd0, 1'b1, 1'b0, a, 32'd0);
        v = bus.rdata;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        step(1'b0, 14'd0, 14'd0, 1'b0, 1'b1, a, d);
    endtask

    // Acknowledge monitor: timing and read data against the scoreboard.
    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (bus.ack) begin
                if (exp_d.size() == 0) begin
                    check_val("ack_spurious", {63'd0, bus.ack}, 64'd0);
                end else begin
                    check_val("ack_cycle", 64'(ncyc), 64'(exp_cyc[0] + 1));
                    if (exp_chk[0]) check_val("rdata", {32'd0, bus.rdata}, {32'd0, exp_d[0]});
                    exp_d.delete(0);
                    exp_chk.delete(0);
                    exp_cyc.delete(0);
                end
            end else if (exp_cyc.size() > 0 && ncyc > exp_cyc[0]) begin
                check_val("ack_missing", {63'd0, bus.ack}, 64'd1);
                exp_d.delete(0);
                exp_chk.delete(0);
                exp_cyc.delete(0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ta, tb_ts, prev, cur;
        rstn_i = 1'b0; trig_i = 1'b0; phase_i = 14'd0; dat_i = 14'd0;
        bus.addr = 16'd0; bus.wen = 1'b0; bus.ren = 1'b0; bus.wdata = 32'd0;
        repeat (3) @(negedge clk_i);
        check_val("rst_ack",      {63'd0, bus.ack},    64'd0);
        check_val("rst_rdata",    {32'd0, bus.rdata},  64'd0);
        check_val("rst_nonempty", {63'd0, nonempty_o}, 64'd0);
        rstn_i = 1'b1;

        // Idle register map, disabled trigger ignored
        rd(16'h0120);
        rd(16'h0100);
        rd(16'h0104);
        rd(16'h01FC);
        pulse();
        rd(16'h0104);
        rd(16'h0110);

        // Single event with known payload
        wr(16'h0100, 32'd1);
        step(1'b1, 14'h0123, 14'h3FFB, 1'b0, 1'b0, 16'd0, 32'd0);
        rd(16'h0104);
        rd(16'h0110);
        rd(16'h0104);
        rd(16'h0108);

        // Two pulses exactly 10 cycles apart
        pulse();
        repeat (9) idle();
        pulse();
        rd_cap(16'h0108, ta);
        rd(16'h010C);
        rd(16'h0110);
        rd_cap(16'h0108, tb_ts);
        rd(16'h0110);
        check_val("ts_diff", {32'd0, tb_ts - ta}, 64'd10);

        // Overfill by one
        repeat (17) pulse();
        rd(16'h0104);
        // Push coincident with pop while full
        step(1'b1, 14'h1555, 14'h2AAA, 1'b1, 1'b0, 16'h0110, 32'd0);
        rd(16'h0104);
        rd(16'h010C);
        // Drain, checking order and monotonic timestamps
        prev = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_cap(16'h0108, cur);
            if (i > 0) check_val("ts_incr", {63'd0, (cur > prev)}, 64'd1);
            prev = cur;
            rd(16'h0110);
        end
        rd(16'h0104);

        // Clear coincident with a trigger, three entries present
        repeat (3) pulse();
        step(1'b1, 14'h0011, 14'h0022, 1'b0, 1'b1, 16'h0100, 32'd3);
        rd(16'h0104);
        pulse();
        rd(16'h0104);
        rd(16'h0110);

        // Asynchronous reset mid-burst
        repeat (3) pulse();
        step(1'b1, 14'h0033, 14'h0044, 1'b1, 1'b0, 16'h0104, 32'd0);
        #2;
        rstn_i = 1'b0;
        trig_i = 1'b0;
        bus.ren = 1'b0;
        #1;
        check_val("arst_ack",      {63'd0, bus.ack},    64'd0);
        check_val("arst_rdata",    {32'd0, bus.rdata},  64'd0);
        check_val("arst_nonempty", {63'd0, nonempty_o}, 64'd0);
        model_q.delete();
        model_ovf = 16'd0;
        model_en  = 1'b0;
        exp_d.delete();
        exp_chk.delete();
        exp_cyc.delete();
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        pulse();
        pulse();
        rd(16'h0104);
        rd(16'h0100);
        idle();
        idle();

        check_val("pending_acks", 64'(exp_d.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/red_pitaya_trigger_timestamp_fifo.md
RED_PITAYA_TRIGGER_TIMESTAMP_FIFO -- requirements
Module: red_pitaya_trigger_timestamp_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 entries (legal 2..8).
REQ-002 SHALL have port clk_i  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port trig_i  input  1  trigger pulse from the upstream trigger block; each high cycle is one event.
REQ-005 SHALL have port phase_i  input  14  phase sample captured with each event.
REQ-006 SHALL have port dat_i  input  14  signed signal sample captured with each event.
REQ-007 SHALL have ports addr input 16, wen input 1, ren input 1, wdata input 32: bus address, write strobe, read strobe, write data.
REQ-008 SHALL have ports ack output 1 and rdata output 32: registered bus acknowledge and read data.
REQ-009 SHALL have port nonempty_o  output  1  high while FIFO holds at least one entry.

Function
REQ-010 SHALL run a free-running 64-bit counter, incremented every cycle, wrapping from all-ones to 0.
REQ-011 SHALL push entry {counter, phase_i, dat_i}, sampled in the same cycle, when trig_i=1 and enable=1.
REQ-012 SHALL make a pushed entry visible (nonempty_o, status, head registers) exactly 1 cycle after the trig_i cycle.
REQ-013 SHALL decode registers: 0x100 ctrl (W bit0 enable, W bit1 clear; R bit0 enable), 0x104 status (R: bit0 empty, bit1 full, [15:8] fill count, [31:16] overflow count), 0x108 head timestamp[31:0], 0x10C head timestamp[63:32], 0x110 head {2'b0, dat[13:0], 2'b0, phase[13:0]}, 0x120 DEPTH_LOG2; all others read 0.
REQ-014 SHALL assert ack 1 cycle after any cycle with wen|ren, for every address, and register rdata in that same cycle.
REQ-015 SHALL pop the head entry on ren at 0x110 when not empty; rdata returns the pre-pop head.
REQ-016 SHALL return 0 on reads of 0x108/0x10C/0x110 when empty; a read of 0x110 when empty SHALL NOT change state.
REQ-017 SHALL, on push while full without a same-cycle pop, drop the event and increment the overflow count, saturating at 0xFFFF.
REQ-018 SHALL, on simultaneous push and pop, perform both; fill count unchanged; this succeeds even when full.
REQ-019 SHALL, on a write to 0x100 with wdata[1]=1, empty the FIFO and zero the overflow count in that cycle; clear overrides a same-cycle push and pop; the clear bit is self-clearing.
REQ-020 SHALL wrap read and write pointers modulo depth; fill count SHALL range 0..2**DEPTH_LOG2.
REQ-021 SHALL ignore trig_i while enable=0; the counter SHALL keep running.

Reset
REQ-022 SHALL, while rstn_i=0, hold: counter 0, enable 0, FIFO empty, pointers 0, overflow 0, ack 0, rdata 0, nonempty_o 0.
REQ-023 SHALL discard all entries on reset mid-operation; FIFO storage contents need no reset.
REQ-024 SHALL release reset synchronously to clk_i, with the first counter increment on the first edge after deassertion.

Structure
REQ-025 SHALL place register offsets, entry width (92 bits) and field positions in a shared package.
REQ-026 SHALL implement storage in a sub-module trigger_fifo_mem (simple dual-port, 1 write, 1 read, registered read).

Verification
REQ-027 Enable, pulse trig_i once with phase_i=0x0123, dat_i=-5 -> 0x104 reads empty=0, fill=1; 0x110 reads 0x3FFB_0123; then empty=1.
REQ-028 Enable, 17 pulses with DEPTH_LOG2=4 -> full=1, fill=16, overflow=1; pop order matches push order, timestamps strictly increasing.
REQ-029 With FIFO full, trig_i coincident with ren 0x110 -> fill stays 16, overflow unchanged, new entry at tail.
REQ-030 Two pulses 10 cycles apart -> popped timestamp difference is exactly 10; a read at 0x10C exercises the upper word.
REQ-031 Clear written in the same cycle as trig_i with 3 entries present -> empty=1, fill=0, overflow=0 next cycle.
REQ-032 rstn_i asserted mid-burst -> all outputs 0 immediately (asynchronously); after release, enable=0 and trig_i is ignored.
